// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle main controller: states, opcodes, ALUOp codes.
// MAIN_CTRL_FSM_JAL_EN adds jal (000011) to the decode dispatch.
package ctrl_pkg;

  typedef enum logic [3:0] {
    StInit   = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StMemAdr = 4'd3,
    StMemRd  = 4'd4,
    StMemWb  = 4'd5,
    StMemWr  = 4'd6,
    StRExec  = 4'd7,
    StRWb    = 4'd8,
    StIExec  = 4'd9,
    StIWb    = 4'd10,
    StBranch = 4'd11,
    StJump   = 4'd12
  } state_e;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;

  localparam logic [2:0] AluOpRType = 3'b000;
  localparam logic [2:0] AluOpAdd   = 3'b100;
  localparam logic [2:0] AluOpSub   = 3'b010;
  localparam logic [2:0] AluOpSlt   = 3'b011;

  // StFetch as the dispatch target doubles as the "illegal opcode" indication.
  function automatic state_e decode_dispatch(input logic [5:0] op);
    state_e st;
    case (op)
      OpRType:        st = StRExec;
      OpLw, OpSw:     st = StMemAdr;
      OpBeq, OpBne:   st = StBranch;
      OpAddi, OpSlti: st = StIExec;
      OpJ:            st = StJump;
`ifdef MAIN_CTRL_FSM_JAL_EN
      OpJal:          st = StJump;
`endif
      default:        st = StFetch;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/main_ctrl_outdec.sv
// Combinational state-to-output decode for the multicycle main controller.
// MAIN_CTRL_FSM_JAL_EN enables the jal link write in JUMP.
module main_ctrl_outdec
  import ctrl_pkg::*;
(
  input  state_e     state_i,
  input  logic [5:0] op_i,
  input  logic       jr_i,
  input  logic       mem_ready_i,
  output logic [2:0] ALUOp_o,
  output logic       PCWrite_o,
  output logic       PCWriteCond_o,
  output logic       PCWriteNe_o,
  output logic       IorD_o,
  output logic       MemRead_o,
  output logic       MemWrite_o,
  output logic       IRWrite_o,
  output logic       RegWrite_o,
  output logic       ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic [1:0] RegDst_o,
  output logic [1:0] MemtoReg_o,
  output logic [1:0] PCSource_o,
  output logic       illegal_o
);

  always_comb begin
    ALUOp_o       = AluOpRType;
    PCWrite_o     = 1'b0;
    PCWriteCond_o = 1'b0;
    PCWriteNe_o   = 1'b0;
    IorD_o        = 1'b0;
    MemRead_o     = 1'b0;
    MemWrite_o    = 1'b0;
    IRWrite_o     = 1'b0;
    RegWrite_o    = 1'b0;
    ALUSrcA_o     = 1'b0;
    ALUSrcB_o     = 2'b00;
    RegDst_o      = 2'b00;
    MemtoReg_o    = 2'b00;
    PCSource_o    = 2'b00;
    illegal_o     = 1'b0;
    unique case (state_i)
      StFetch: begin
        MemRead_o = 1'b1;
        ALUSrcB_o = 2'b01;
        ALUOp_o   = AluOpAdd;
        IRWrite_o = mem_ready_i;
        PCWrite_o = mem_ready_i;
      end
      StDecode: begin
        ALUSrcB_o = 2'b11;
        ALUOp_o   = AluOpAdd;
        illegal_o = (decode_dispatch(op_i) == StFetch);
      end
      StMemAdr: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = 2'b10;
        ALUOp_o   = AluOpAdd;
      end
      StMemRd: begin
        MemRead_o = 1'b1;
        IorD_o    = 1'b1;
      end
      StMemWb: begin
        RegWrite_o = 1'b1;
        MemtoReg_o = 2'b01;
      end
      StMemWr: begin
        IorD_o     = 1'b1;
        MemWrite_o = mem_ready_i;
      end
      StRExec: begin
        ALUSrcA_o = 1'b1;
        if (jr_i) begin
          PCWrite_o  = 1'b1;
          PCSource_o = 2'b11;
        end
      end
      StRWb: begin
        RegWrite_o = 1'b1;
        RegDst_o   = 2'b01;
      end
      StIExec: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = 2'b10;
        ALUOp_o   = (op_i == OpSlti) ? AluOpSlt : AluOpAdd;
      end
      StIWb: RegWrite_o = 1'b1;
      StBranch: begin
        ALUSrcA_o     = 1'b1;
        ALUOp_o       = AluOpSub;
        PCSource_o    = 2'b01;
        PCWriteCond_o = (op_i == OpBeq);
        PCWriteNe_o   = (op_i == OpBne);
      end
      StJump: begin
        PCWrite_o  = 1'b1;
        PCSource_o = 2'b10;
`ifdef MAIN_CTRL_FSM_JAL_EN
        if (op_i == OpJal) begin
          RegWrite_o = 1'b1;
          RegDst_o   = 2'b10;
          MemtoReg_o = 2'b10;
        end
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/main_ctrl_fsm.sv
// Multicycle MIPS-style main controller: state register and next-state logic.
// MAIN_CTRL_FSM_JAL_EN enables jal decoding (see ctrl_pkg / main_ctrl_outdec).
module main_ctrl_fsm
  import ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] op_i,
  input  logic       jr_i,
  input  logic       mem_ready_i,
  output logic [2:0] ALUOp_o,
  output logic       PCWrite_o,
  output logic       PCWriteCond_o,
  output logic       PCWriteNe_o,
  output logic       IorD_o,
  output logic       MemRead_o,
  output logic       MemWrite_o,
  output logic       IRWrite_o,
  output logic       RegWrite_o,
  output logic       ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic [1:0] RegDst_o,
  output logic [1:0] MemtoReg_o,
  output logic [1:0] PCSource_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  state_e r_state;
  state_e w_state_next;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= StInit;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StInit:   w_state_next = StFetch;
      StFetch:  if (mem_ready_i) w_state_next = StDecode;
      StDecode: w_state_next = decode_dispatch(op_i);
      StMemAdr: w_state_next = (op_i == OpLw) ? StMemRd : StMemWr;
      StMemRd:  if (mem_ready_i) w_state_next = StMemWb;
      StMemWb:  w_state_next = StFetch;
      StMemWr:  if (mem_ready_i) w_state_next = StFetch;
      StRExec:  w_state_next = jr_i ? StFetch : StRWb;
      StRWb:    w_state_next = StFetch;
      StIExec:  w_state_next = StIWb;
      StIWb:    w_state_next = StFetch;
      StBranch: w_state_next = StFetch;
      StJump:   w_state_next = StFetch;
      default:  w_state_next = StInit;
    endcase
  end

  assign state_o = r_state;

  main_ctrl_outdec u_outdec (
    .state_i       (r_state),
    .op_i          (op_i),
    .jr_i          (jr_i),
    .mem_ready_i   (mem_ready_i),
    .ALUOp_o       (ALUOp_o),
    .PCWrite_o     (PCWrite_o),
    .PCWriteCond_o (PCWriteCond_o),
    .PCWriteNe_o   (PCWriteNe_o),
    .IorD_o        (IorD_o),
    .MemRead_o     (MemRead_o),
    .MemWrite_o    (MemWrite_o),
    .IRWrite_o     (IRWrite_o),
    .RegWrite_o    (RegWrite_o),
    .ALUSrcA_o     (ALUSrcA_o),
    .ALUSrcB_o     (ALUSrcB_o),
    .RegDst_o      (RegDst_o),
    .MemtoReg_o    (MemtoReg_o),
    .PCSource_o    (PCSource_o),
    .illegal_o     (illegal_o)
  );

endmodule

// File: tb/tb_main_ctrl_fsm.sv
// Table-driven bench for main_ctrl_fsm plus directed lw-stall and reset-in-MEMWR sequences.
// Honours MAIN_CTRL_FSM_JAL_EN for the jal expectations.
module tb_main_ctrl_fsm;
  import ctrl_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [5:0] op_i;
  logic       jr_i;
  logic       mem_ready_i;
  logic [2:0] ALUOp_o;
  logic       PCWrite_o, PCWriteCond_o, PCWriteNe_o, IorD_o, MemRead_o, MemWrite_o;
  logic       IRWrite_o, RegWrite_o, ALUSrcA_o, illegal_o;
  logic [1:0] ALUSrcB_o, RegDst_o, MemtoReg_o, PCSource_o;
  logic [3:0] state_o;

  main_ctrl_fsm dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .op_i          (op_i),
    .jr_i          (jr_i),
    .mem_ready_i   (mem_ready_i),
    .ALUOp_o       (ALUOp_o),
    .PCWrite_o     (PCWrite_o),
    .PCWriteCond_o (PCWriteCond_o),
    .PCWriteNe_o   (PCWriteNe_o),
    .IorD_o        (IorD_o),
    .MemRead_o     (MemRead_o),
    .MemWrite_o    (MemWrite_o),
    .IRWrite_o     (IRWrite_o),
    .RegWrite_o    (RegWrite_o),
    .ALUSrcA_o     (ALUSrcA_o),
    .ALUSrcB_o     (ALUSrcB_o),
    .RegDst_o      (RegDst_o),
    .MemtoReg_o    (MemtoReg_o),
    .PCSource_o    (PCSource_o),
    .illegal_o     (illegal_o),
    .state_o       (state_o)
  );

  always #5 clk_i = ~clk_i;

  logic [20:0] w_out;
  assign w_out = {ALUOp_o, PCWrite_o, PCWriteCond_o, PCWriteNe_o, IorD_o, MemRead_o, MemWrite_o,
                  IRWrite_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, RegDst_o, MemtoReg_o, PCSource_o,
                  illegal_o};

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        jr;
    logic        rdy;
    logic [3:0]  st;
    logic [20:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [20:0] mk(input logic [2:0] aop, input logic pcw, input logic pcwc,
                                     input logic pcwne, input logic iord, input logic mrd,
                                     input logic mwr, input logic irw, input logic rw,
                                     input logic sa, input logic [1:0] sb, input logic [1:0] rd,
                                     input logic [1:0] m2r, input logic [1:0] ps,
                                     input logic ill);
    return {aop, pcw, pcwc, pcwne, iord, mrd, mwr, irw, rw, sa, sb, rd, m2r, ps, ill};
  endfunction

  function automatic void add(input logic r, input logic [5:0] op, input logic jr,
                              input logic rdy, input state_e st, input logic [20:0] exp);
    vec_t v;
    v.rst = r; v.op = op; v.jr = jr; v.rdy = rdy; v.st = st; v.exp = exp;
    vecs.push_back(v);
  endfunction

  task automatic check(input string nm, input int unsigned act, input int unsigned exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [5:0] op, input logic jr, input logic rdy);
    @(negedge clk_i);
    rst_i = r; op_i = op; jr_i = jr; mem_ready_i = rdy;
    #1;
  endtask

  logic [20:0] e_zero, e_fetch_r, e_fetch_s, e_dec, e_dec_ill, e_rexec, e_rexec_jr, e_rwb;
  logic [20:0] e_bne, e_jump, e_jal, e_iexec_add, e_iexec_slt, e_iwb, e_memwr_s;

  initial begin
    e_zero      = '0;
    //              aop     pcw  pcwc pcwne iord mrd  mwr  irw  rw   sa   sb     rd     m2r    ps     ill
    e_fetch_r   = mk(3'b100,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,2'b01,2'b00,2'b00,2'b00,1'b0);
    e_fetch_s   = mk(3'b100,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,2'b00,1'b0);
    e_dec       = mk(3'b100,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,2'b00,1'b0);
    e_dec_ill   = mk(3'b100,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,2'b00,1'b1);
    e_rexec     = mk(3'b000,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,2'b00,1'b0);
    e_rexec_jr  = mk(3'b000,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,2'b11,1'b0);
    e_rwb       = mk(3'b000,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b01,2'b00,2'b00,1'b0);
    e_bne       = mk(3'b010,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,2'b01,1'b0);
    e_jump      = mk(3'b000,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b10,1'b0);
    e_jal       = mk(3'b000,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b10,2'b10,2'b10,1'b0);
    e_iexec_add = mk(3'b100,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,2'b00,1'b0);
    e_iexec_slt = mk(3'b011,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,2'b00,1'b0);
    e_iwb       = mk(3'b000,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0);
    e_memwr_s   = mk(3'b000,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0);

    // Reset, then R-type add through RWB
    add(1'b0, OpRType, 1'b0, 1'b1, StInit,   e_zero);
    add(1'b1, OpRType, 1'b0, 1'b1, StInit,   e_zero);
    add(1'b1, OpRType, 1'b0, 1'b1, StFetch,  e_fetch_r);
    add(1'b1, OpRType, 1'b0, 1'b1, StDecode, e_dec);
    add(1'b1, OpRType, 1'b0, 1'b1, StRExec,  e_rexec);
    add(1'b1, OpRType, 1'b0, 1'b1, StRWb,    e_rwb);
    // jr: REXEC redirects the PC and skips RWB
    add(1'b1, OpRType, 1'b1, 1'b1, StFetch,  e_fetch_r);
    add(1'b1, OpRType, 1'b1, 1'b1, StDecode, e_dec);
    add(1'b1, OpRType, 1'b1, 1'b1, StRExec,  e_rexec_jr);
    // bne
    add(1'b1, OpBne,   1'b0, 1'b1, StFetch,  e_fetch_r);
    add(1'b1, OpBne,   1'b0, 1'b1, StDecode, e_dec);
    add(1'b1, OpBne,   1'b0, 1'b1, StBranch, e_bne);
    // illegal 111111: single pulse, next FETCH row must show illegal_o low
    add(1'b1, 6'h3f,   1'b0, 1'b1, StFetch,  e_fetch_r);
    add(1'b1, 6'h3f,   1'b0, 1'b1, StDecode, e_dec_ill);
    // jal
    add(1'b1, OpJal,   1'b0, 1'b1, StFetch,  e_fetch_r);
`ifdef MAIN_CTRL_FSM_JAL_EN
    add(1'b1, OpJal,   1'b0, 1'b1, StDecode, e_dec);
    add(1'b1, OpJal,   1'b0, 1'b1, StJump,   e_jal);
`else
    add(1'b1, OpJal,   1'b0, 1'b1, StDecode, e_dec_ill);
`endif
    // j
    add(1'b1, OpJ,     1'b0, 1'b1, StFetch,  e_fetch_r);
    add(1'b1, OpJ,     1'b0, 1'b1, StDecode, e_dec);
    add(1'b1, OpJ,     1'b0, 1'b1, StJump,   e_jump);
    // addi, slti
    add(1'b1, OpAddi,  1'b0, 1'b1, StFetch,  e_fetch_r);
    add(1'b1, OpAddi,  1'b0, 1'b1, StDecode, e_dec);
    add(1'b1, OpAddi,  1'b0, 1'b1, StIExec,  e_iexec_add);
    add(1'b1, OpAddi,  1'b0, 1'b1, StIWb,    e_iwb);
    add(1'b1, OpSlti,  1'b0, 1'b1, StFetch,  e_fetch_r);
    add(1'b1, OpSlti,  1'b0, 1'b1, StDecode, e_dec);
    add(1'b1, OpSlti,  1'b0, 1'b1, StIExec,  e_iexec_slt);
    add(1'b1, OpSlti,  1'b0, 1'b1, StIWb,    e_iwb);
    // park in FETCH with memory not ready
    add(1'b1, OpRType, 1'b0, 1'b0, StFetch,  e_fetch_s);

    rst_i = 1'b1; op_i = '0; jr_i = 1'b0; mem_ready_i = 1'b1;
    #1 rst_i = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].op, vecs[i].jr, vecs[i].rdy);
      check($sformatf("row%0d_state", i), state_o, vecs[i].st);
      check($sformatf("row%0d_outputs", i), w_out, vecs[i].exp);
    end

    // lw with 2 stall cycles in FETCH and 3 in MEMRD
    begin
      logic   rdy_seq[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      state_e st_seq[11]  = '{StFetch, StFetch, StFetch, StDecode, StMemAdr, StMemRd, StMemRd,
                              StMemRd, StMemRd, StMemWb, StFetch};
      int irw_cnt = 0;
      int wb_cnt  = 0;
      for (int i = 0; i < 11; i++) begin
        step(1'b1, OpLw, 1'b0, rdy_seq[i]);
        check($sformatf("lw%0d_state", i), state_o, st_seq[i]);
        if (IRWrite_o) irw_cnt++;
        if (RegWrite_o && MemtoReg_o == 2'b01) wb_cnt++;
      end
      check("lw_irwrite_pulses", irw_cnt, 1);
      check("lw_memwb_pulses", wb_cnt, 1);
    end

    // sw interrupted by reset while waiting in MEMWR
    step(1'b1, OpSw, 1'b0, 1'b1);
    check("sw_fetch", state_o, StFetch);
    step(1'b1, OpSw, 1'b0, 1'b1);
    step(1'b1, OpSw, 1'b0, 1'b1);
    check("sw_memadr", state_o, StMemAdr);
    step(1'b1, OpSw, 1'b0, 1'b0);
    check("sw_memwr_state", state_o, StMemWr);
    check("sw_memwr_outputs", w_out, e_memwr_s);
    rst_i = 1'b0;
    #1;
    check("rst_async_state", state_o, StInit);
    check("rst_async_outputs", w_out, e_zero);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, OpSw, 1'b0, 1'b1);
      check($sformatf("rst_hold%0d_state", i), state_o, StInit);
      check($sformatf("rst_hold%0d_memwrite", i), MemWrite_o, 0);
    end
    step(1'b1, OpSw, 1'b0, 1'b1);
    check("rst_release_state", state_o, StInit);
    check("rst_release_memwrite", MemWrite_o, 0);
    step(1'b1, OpSw, 1'b0, 1'b1);
    check("post_rst_fetch_state", state_o, StFetch);
    check("post_rst_fetch_outputs", w_out, e_fetch_r);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
